// File: rtl/kd_query_scheduler.sv
// Two-phase sequencer for internal_node_tree: counts node words during LOAD,
// then alternates patches across the two tree ports and returns leaf indices
// in dispatch order.
module kd_query_scheduler #(
    parameter int unsigned PATCH_WIDTH        = 55,
    parameter int unsigned ADDRESS_WIDTH      = 8,
    parameter int unsigned NUM_INTERNAL_NODES = 63,
    parameter int unsigned OUT_DEPTH          = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 node_wr_en,
    output logic                                 fsm_enable,
    output logic                                 load_done,
    input  logic                                 patch_valid,
    output logic                                 patch_ready,
    input  logic [PATCH_WIDTH-1:0]               patch_data,
    output logic                                 patch_en,
    output logic [PATCH_WIDTH-1:0]               patch_in,
    output logic                                 patch_two_en,
    output logic [PATCH_WIDTH-1:0]               patch_in_two,
    input  logic                                 leaf_en,
    input  logic [ADDRESS_WIDTH-1:0]             leaf_index,
    input  logic                                 leaf_two_en,
    input  logic [ADDRESS_WIDTH-1:0]             leaf_index_two,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ADDRESS_WIDTH-1:0]             out_leaf,
    output logic [$clog2(2*OUT_DEPTH+1)-1:0]     outstanding,
    output logic                                 error
);
    localparam int unsigned CntW = $clog2(NUM_INTERNAL_NODES + 1);
    localparam int unsigned CrW  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(OUT_DEPTH);
    localparam int unsigned OutW = $clog2(2 * OUT_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StQuery} state_e;

    state_e                   state_q;
    logic [CntW-1:0]          node_cnt_q;
    logic                     fsm_enable_q, load_done_q;

    logic                     disp_sel_q, rd_sel_q;
    logic [CrW-1:0]           credit_q   [2];
    logic [CrW-1:0]           inflight_q [2];
    logic [CrW-1:0]           cnt_q      [2];
    logic [PtrW-1:0]          wr_ptr_q   [2];
    logic [PtrW-1:0]          rd_ptr_q   [2];
    logic [ADDRESS_WIDTH-1:0] mem_q      [2][OUT_DEPTH];
    logic [OutW-1:0]          outstanding_q;
    logic                     error_q;
    logic                     patch_en_q, patch_two_en_q;
    logic [PATCH_WIDTH-1:0]   patch_in_q, patch_in_two_q;

    logic                     load_last, reload, accept, pop, spurious;
    logic [1:0]               disp, popp, push, leaf_v;
    logic [ADDRESS_WIDTH-1:0] leaf_d [2];

    assign load_last = (state_q == StLoad) && node_wr_en &&
                       (node_cnt_q == CntW'(NUM_INTERNAL_NODES - 1));
    // Reload is only safe once every dispatched query has been popped
    assign reload    = (state_q == StQuery) && start && (outstanding_q == '0);

    assign patch_ready = (state_q == StQuery) && (credit_q[disp_sel_q] != '0);
    assign accept      = patch_valid && patch_ready;
    assign out_valid   = (cnt_q[rd_sel_q] != '0);
    assign out_leaf    = mem_q[rd_sel_q][rd_ptr_q[rd_sel_q]];
    assign pop         = out_valid && out_ready;

    assign disp   = {accept && disp_sel_q, accept && !disp_sel_q};
    assign popp   = {pop && rd_sel_q, pop && !rd_sel_q};
    assign leaf_v = {leaf_two_en, leaf_en};
    assign leaf_d[0] = leaf_index;
    assign leaf_d[1] = leaf_index_two;
    // A result is only accepted on a port with a dispatch still awaiting its answer
    assign push[0]  = leaf_v[0] && (inflight_q[0] != '0);
    assign push[1]  = leaf_v[1] && (inflight_q[1] != '0);
    assign spurious = |(leaf_v & ~push);

    assign fsm_enable   = fsm_enable_q;
    assign load_done    = load_done_q;
    assign patch_en     = patch_en_q;
    assign patch_in     = patch_in_q;
    assign patch_two_en = patch_two_en_q;
    assign patch_in_two = patch_in_two_q;
    assign outstanding  = outstanding_q;
    assign error        = error_q;

    // Phase FSM with registered fsm_enable / load_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            node_cnt_q   <= '0;
            fsm_enable_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StLoad;
                        node_cnt_q   <= '0;
                        fsm_enable_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (node_wr_en) begin
                        node_cnt_q <= node_cnt_q + CntW'(1);
                        if (load_last) begin
                            state_q      <= StQuery;
                            fsm_enable_q <= 1'b0;
                            load_done_q  <= 1'b1;
                        end
                    end
                end
                StQuery: begin
                    if (reload) begin
                        state_q      <= StLoad;
                        node_cnt_q   <= '0;
                        fsm_enable_q <= 1'b1;
                        load_done_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Dispatch registers, per-port credits, result queues and bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_sel_q     <= 1'b0;
            rd_sel_q       <= 1'b0;
            outstanding_q  <= '0;
            error_q        <= 1'b0;
            patch_en_q     <= 1'b0;
            patch_two_en_q <= 1'b0;
            patch_in_q     <= '0;
            patch_in_two_q <= '0;
            for (int p = 0; p < 2; p++) begin
                credit_q[p]   <= '0;
                inflight_q[p] <= '0;
                cnt_q[p]      <= '0;
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
                for (int i = 0; i < OUT_DEPTH; i++) begin
                    mem_q[p][i] <= '0;
                end
            end
        end else begin
            patch_en_q     <= disp[0];
            patch_two_en_q <= disp[1];
            if (disp[0]) patch_in_q <= patch_data;
            if (disp[1]) patch_in_two_q <= patch_data;
            if (accept) disp_sel_q <= ~disp_sel_q;
            if (pop) rd_sel_q <= ~rd_sel_q;
            outstanding_q <= outstanding_q + OutW'(accept) - OutW'(pop);
            error_q       <= error_q | spurious;
            for (int p = 0; p < 2; p++) begin
                if (load_last) begin
                    credit_q[p] <= CrW'(OUT_DEPTH);
                end else begin
                    credit_q[p] <= credit_q[p] - CrW'(disp[p]) + CrW'(popp[p]);
                end
                inflight_q[p] <= inflight_q[p] + CrW'(disp[p]) - CrW'(push[p]);
                cnt_q[p]      <= cnt_q[p] + CrW'(push[p]) - CrW'(popp[p]);
                if (push[p]) begin
                    mem_q[p][wr_ptr_q[p]] <= leaf_d[p];
                    wr_ptr_q[p]           <= wr_ptr_q[p] + PtrW'(1);
                end
                if (popp[p]) rd_ptr_q[p] <= rd_ptr_q[p] + PtrW'(1);
            end
        end
    end
endmodule

// File: tb/tb_kd_query_scheduler.sv
// Directed bench for kd_query_scheduler: load, dispatch order, reordering,
// backpressure, simultaneous results, spurious result and mid-query reset.
module tb_kd_query_scheduler;
    localparam int unsigned PW = 55;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, node_wr_en = 1'b0;
    logic          fsm_enable, load_done;
    logic          patch_valid = 1'b0, patch_ready;
    logic [PW-1:0] patch_data = '0;
    logic          patch_en, patch_two_en;
    logic [PW-1:0] patch_in, patch_in_two;
    logic          leaf_en = 1'b0, leaf_two_en = 1'b0;
    logic [AW-1:0] leaf_index = '0, leaf_index_two = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [AW-1:0] out_leaf;
    logic [3:0]    outstanding;
    logic          error;

    int n_cmp = 0;
    int n_err = 0;

    kd_query_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .node_wr_en(node_wr_en),
        .fsm_enable(fsm_enable), .load_done(load_done),
        .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_data(patch_data),
        .patch_en(patch_en), .patch_in(patch_in),
        .patch_two_en(patch_two_en), .patch_in_two(patch_in_two),
        .leaf_en(leaf_en), .leaf_index(leaf_index),
        .leaf_two_en(leaf_two_en), .leaf_index_two(leaf_index_two),
        .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf),
        .outstanding(outstanding), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_tree(input int gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("load_fsm_en", fsm_enable, 1);
        for (int i = 0; i < 63; i++) begin
            node_wr_en = 1'b1;
            tick();
            node_wr_en = 1'b0;
            if (i == 61) begin
                check_eq("load62_fsm_en", fsm_enable, 1);
                check_eq("load62_done", load_done, 0);
            end
            for (int g = 1; g < gap; g++) tick();
        end
        check_eq("load_done_fsm_en", fsm_enable, 0);
        check_eq("load_done", load_done, 1);
    endtask

    initial begin
        int acc;
        logic [AW-1:0] exp_seq [8];
        exp_seq[0] = 8'd11; exp_seq[1] = 8'd12; exp_seq[2] = 8'd13; exp_seq[3] = 8'd14;
        exp_seq[4] = 8'd15; exp_seq[5] = 8'd16; exp_seq[6] = 8'd17; exp_seq[7] = 8'd99;

        // Reset state
        tick(); tick();
        check_eq("rst_fsm_en", fsm_enable, 0);
        check_eq("rst_load_done", load_done, 0);
        check_eq("rst_ready", patch_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_error", error, 0);
        rst = 1'b0;
        tick();
        check_eq("idle_fsm_en", fsm_enable, 0);

        // Load with pulses 3 cycles apart
        load_tree(3);

        // Dispatch and in-order return
        patch_valid = 1'b1;
        patch_data  = 55'h0FBFCDFFFD4404F;
        check_eq("q_ready0", patch_ready, 1);
        tick();
        check_eq("d0_en", patch_en, 1);
        check_eq("d0_two_en", patch_two_en, 0);
        check_eq("d0_data", patch_in, 55'h0FBFCDFFFD4404F);
        patch_data = 55'h117FDDF27F5012;
        tick();
        patch_valid = 1'b0;
        check_eq("d1_en", patch_en, 0);
        check_eq("d1_two_en", patch_two_en, 1);
        check_eq("d1_data", patch_in_two, 55'h117FDDF27F5012);
        check_eq("d1_outstanding", outstanding, 2);
        tick();
        check_eq("d2_two_en", patch_two_en, 0);
        leaf_en = 1'b1; leaf_index = 8'd59;
        tick();
        leaf_en = 1'b0;
        leaf_two_en = 1'b1; leaf_index_two = 8'd60;
        check_eq("ord_valid0", out_valid, 1);
        check_eq("ord_leaf0", out_leaf, 59);
        tick();
        leaf_two_en = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("ord_leaf1", out_leaf, 60);
        check_eq("ord_outstanding1", outstanding, 1);
        tick();
        out_ready = 1'b0;
        check_eq("ord_empty", out_valid, 0);
        check_eq("ord_outstanding0", outstanding, 0);

        // Port 1 returns before port 0
        patch_valid = 1'b1; patch_data = 55'h1;
        tick();
        patch_data = 55'h2;
        tick();
        patch_valid = 1'b0;
        leaf_two_en = 1'b1; leaf_index_two = 8'd5;
        tick();
        leaf_two_en = 1'b0;
        check_eq("reo_wait0", out_valid, 0);
        tick(); tick();
        check_eq("reo_wait2", out_valid, 0);
        leaf_en = 1'b1; leaf_index = 8'd22;
        tick();
        leaf_en = 1'b0;
        check_eq("reo_valid", out_valid, 1);
        check_eq("reo_leaf0", out_leaf, 22);
        out_ready = 1'b1;
        tick();
        check_eq("reo_leaf1", out_leaf, 5);
        tick();
        out_ready = 1'b0;
        check_eq("reo_empty", out_valid, 0);

        // Backpressure: credits cap acceptance at 2*OUT_DEPTH
        acc = 0;
        patch_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            patch_data = PW'(i + 100);
            if (patch_ready) acc++;
            tick();
        end
        check_eq("bp_accepted", acc, 8);
        check_eq("bp_ready", patch_ready, 0);
        check_eq("bp_outstanding", outstanding, 8);
        // Simultaneous results on both ports
        for (int i = 0; i < 4; i++) begin
            leaf_en = 1'b1; leaf_index = AW'(10 + 2 * i);
            leaf_two_en = 1'b1; leaf_index_two = AW'(11 + 2 * i);
            tick();
        end
        leaf_en = 1'b0; leaf_two_en = 1'b0;
        check_eq("bp_head", out_leaf, 10);
        check_eq("bp_ready_full", patch_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_ready_after_pop", patch_ready, 1);
        check_eq("bp_outstanding7", outstanding, 7);
        tick();
        patch_valid = 1'b0;
        check_eq("bp_refill_en", patch_en, 1);
        check_eq("bp_outstanding8", outstanding, 8);
        check_eq("bp_ready_again", patch_ready, 0);
        leaf_en = 1'b1; leaf_index = 8'd99;
        tick();
        leaf_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drain_leaf%0d", i), out_leaf, exp_seq[i]);
            tick();
        end
        out_ready = 1'b0;
        check_eq("drain_empty", out_valid, 0);
        check_eq("drain_outstanding", outstanding, 0);
        check_eq("no_error_yet", error, 0);

        // Spurious port-1 result
        leaf_two_en = 1'b1; leaf_index_two = 8'd77;
        tick();
        leaf_two_en = 1'b0;
        check_eq("spur_error", error, 1);
        check_eq("spur_dropped", out_valid, 0);
        tick(); tick();
        check_eq("spur_sticky", error, 1);

        // Start with outstanding queries is ignored; then reset mid-query
        patch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            patch_data = PW'(i + 7);
            tick();
        end
        patch_valid = 1'b0;
        check_eq("pre_rst_outstanding", outstanding, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ignored", load_done, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_load_done", load_done, 0);
        check_eq("mid_rst_outstanding", outstanding, 0);
        check_eq("mid_rst_error", error, 0);
        check_eq("mid_rst_ready", patch_ready, 0);
        check_eq("mid_rst_data", patch_in, 0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check_eq("post_rst_idle", fsm_enable, 0);
        check_eq("post_rst_ready", patch_ready, 0);
        load_tree(1);
        check_eq("reload_ready", patch_ready, 1);

        // Start with nothing outstanding returns to LOAD
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("reload_done_drop", load_done, 0);
        check_eq("reload_fsm_en", fsm_enable, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
